// File: rtl/bidir_pad_bus_ctrl_if.sv
// Bundle of the core-side request/stream signals and the pad-side signals of
// bidir_pad_bus_ctrl.
//
// Modports:
//   master : the environment. This is the core issuing requests plus the pad
//            group returning readback on pad_c.
//   slave  : the controller itself.
//
// Signals (direction given as seen by the slave/controller):
//   req_valid/req_ready/req_wr/req_len  burst request handshake (in/out/in/in)
//   wd_valid/wd_ready/wd_data           write beat stream (in/out/in)
//   rd_valid/rd_data/rd_last            read beat stream, no backpressure (out)
//   busy                                controller not idle (out)
//   pad_i/pad_oen/pad_c                 PADBID I, OEN (active low), C (out/out/in)
//   pad_stb/pad_dir                     beat strobe and drive direction (out)
interface bidir_pad_bus_ctrl_if #(
    parameter int unsigned DW   = 4,
    parameter int unsigned LENW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [LENW-1:0] req_len;
    logic            wd_valid;
    logic            wd_ready;
    logic [DW-1:0]   wd_data;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            busy;
    logic [DW-1:0]   pad_i;
    logic [DW-1:0]   pad_oen;
    logic [DW-1:0]   pad_c;
    logic            pad_stb;
    logic            pad_dir;

    modport master (
        output req_valid, req_wr, req_len, wd_valid, wd_data, pad_c,
        input  req_ready, wd_ready, rd_valid, rd_data, rd_last, busy,
               pad_i, pad_oen, pad_stb, pad_dir
    );

    modport slave (
        input  req_valid, req_wr, req_len, wd_valid, wd_data, pad_c,
        output req_ready, wd_ready, rd_valid, rd_data, rd_last, busy,
               pad_i, pad_oen, pad_stb, pad_dir
    );
endinterface

// File: rtl/bidir_pad_bus_ctrl.sv
// Controller for the near end of a group of PADBID bidirectional pads.
//
// Turns core burst requests into half-duplex burst writes and reads on a
// DW-bit pad bus. Each burst is req_len+1 beats. After every burst the
// controller spends TA_CYCLES cycles in a turnaround state with the pads
// released, so the controller and the far-end device never drive together.
//
// Ports:
//   CK              clock, rising edge
//   RST             synchronous active-high reset
//   bus             bidir_pad_bus_ctrl_if.slave: request, write stream, read
//                   stream, busy, and the pad signals (pad_i, pad_oen, pad_c,
//                   pad_stb, pad_dir)
//   err_clr         (optional) clears err_contention
//   err_contention  (optional) sticky flag: pad readback disagreed with the
//                   value being driven during a write
//
// Optional feature: define BIDIR_PAD_BUS_CONTENTION_EN to add the contention
// checker and its two ports. Without it the core behaviour is identical.
//
// Timing summary (cycle 0 = request accepted):
//   write: beat k consumed in cycle c shows on the pads (pad_stb=1, pad_oen=0)
//          in cycle c+1. The cycle after the last beat is the first TURN cycle
//          and still shows that beat; the next edge releases the pads.
//   read:  pad_stb is high for the req_len+1 RD cycles; pad_c is sampled at
//          the end of each strobe cycle and appears on rd_data one cycle later.
//          The final beat (rd_last) emerges in the first TURN cycle.
module bidir_pad_bus_ctrl #(
    parameter int unsigned DW        = 4,
    parameter int unsigned LENW      = 4,
    parameter int unsigned TA_CYCLES = 1
) (
    input  logic CK,
    input  logic RST,
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
    input  logic err_clr,
    output logic err_contention,
`endif
    bidir_pad_bus_ctrl_if.slave bus
);

    // A turnaround of zero would let the two ends overlap, so clamp to one.
    localparam int unsigned TA_EFF  = (TA_CYCLES < 1) ? 1 : TA_CYCLES;
    localparam int unsigned TAW     = (TA_EFF > 1) ? $clog2(TA_EFF) : 1;
    localparam logic [TAW-1:0] TA_LOAD = TAW'(TA_EFF - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StTurn
    } state_e;

    state_e          state_q;
    logic [LENW-1:0] beat_cnt_q;   // beats remaining minus one
    logic [TAW-1:0]  ta_cnt_q;     // turnaround cycles remaining minus one
    logic [DW-1:0]   pad_i_q;
    logic            pad_oen_q;    // one bit: every OEN in the group is equal
    logic            pad_stb_q;
    logic            pad_dir_q;
    logic            rd_valid_q;
    logic [DW-1:0]   rd_data_q;
    logic            rd_last_q;
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
    logic            err_q;
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            ta_cnt_q   <= '0;
            pad_i_q    <= '0;
            pad_oen_q  <= 1'b1;
            pad_stb_q  <= 1'b0;
            pad_dir_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // Read beats are single-cycle pulses.
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    pad_oen_q <= 1'b1;
                    pad_stb_q <= 1'b0;
                    pad_dir_q <= 1'b0;
                    // req_ready is high whenever we are here and out of reset.
                    if (bus.req_valid) begin
                        beat_cnt_q <= bus.req_len;
                        if (bus.req_wr) begin
                            state_q   <= StWr;
                            pad_dir_q <= 1'b1;
                        end else begin
                            // Read strobes start straight away so the RD state
                            // lasts exactly req_len+1 strobe cycles.
                            state_q   <= StRd;
                            pad_stb_q <= 1'b1;
                        end
                    end
                end

                StWr: begin
                    if (bus.wd_valid) begin
                        pad_i_q   <= bus.wd_data;
                        pad_oen_q <= 1'b0;
                        pad_stb_q <= 1'b1;
                        if (beat_cnt_q == '0) begin
                            // Last beat still shows on the pads during the
                            // first TURN cycle; TURN releases them after that.
                            state_q  <= StTurn;
                            ta_cnt_q <= TA_LOAD;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - LENW'(1);
                        end
                    end else begin
                        // Stall: keep driving the previous value, no strobe.
                        pad_stb_q <= 1'b0;
                    end
                end

                StRd: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= bus.pad_c;
                    if (beat_cnt_q == '0) begin
                        rd_last_q <= 1'b1;
                        pad_stb_q <= 1'b0;
                        state_q   <= StTurn;
                        ta_cnt_q  <= TA_LOAD;
                    end else begin
                        beat_cnt_q <= beat_cnt_q - LENW'(1);
                    end
                end

                StTurn: begin
                    pad_oen_q <= 1'b1;
                    pad_stb_q <= 1'b0;
                    pad_dir_q <= 1'b0;
                    if (ta_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        ta_cnt_q <= ta_cnt_q - TAW'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase

`ifdef BIDIR_PAD_BUS_CONTENTION_EN
            // While we drive a strobed beat the readback must match what we
            // drive; anything else means the far end is driving too. Setting
            // takes priority over a simultaneous clear.
            if (pad_stb_q && pad_dir_q && !pad_oen_q && (bus.pad_c != pad_i_q)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
`endif
        end
    end

    // req_ready is forced low while reset is asserted, even before the first
    // edge has brought the state back to idle.
    assign bus.req_ready = (state_q == StIdle) && !RST;
    assign bus.wd_ready  = (state_q == StWr);
    assign bus.busy      = (state_q != StIdle);
    assign bus.pad_i     = pad_i_q;
    assign bus.pad_oen   = {DW{pad_oen_q}};
    assign bus.pad_stb   = pad_stb_q;
    assign bus.pad_dir   = pad_dir_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_last   = rd_last_q;

`ifdef BIDIR_PAD_BUS_CONTENTION_EN
    assign err_contention = err_q;
`endif

endmodule

// File: tb/tb_bidir_pad_bus_ctrl.sv
// Self-checking bench for bidir_pad_bus_ctrl (TA_CYCLES=3).
// Each burst's expected pad/stream trace is computed cycle by cycle from the
// burst rules (beat k consumed in cycle c shows on the pads in c+1, read
// strobes in cycles 1..N, read data one cycle after its strobe, TA-cycle
// turnaround). Define BIDIR_PAD_BUS_CONTENTION_EN to also check the
// contention flag.
module tb_bidir_pad_bus_ctrl;
    localparam int unsigned DW   = 4;
    localparam int unsigned LENW = 4;
    localparam int unsigned TA   = 3;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    bidir_pad_bus_ctrl_if #(.DW(DW), .LENW(LENW)) bus ();

`ifdef BIDIR_PAD_BUS_CONTENTION_EN
    logic err_clr = 1'b0;
    logic err_contention;
`endif

    bidir_pad_bus_ctrl #(
        .DW        (DW),
        .LENW      (LENW),
        .TA_CYCLES (TA)
    ) dut (
        .CK             (CK),
        .RST            (RST),
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
        .err_clr        (err_clr),
        .err_contention (err_contention),
`endif
        .bus            (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state persisting across bursts.
    logic [3:0] m_pad_i;
    logic [3:0] m_rd_data;
    logic       m_err;

    // Stimulus for the next burst.
    logic [3:0] s_data[16];
    int         s_gap[16];
    logic [3:0] s_pc[16];
    bit         s_noise;
    bit         s_force0;

    // {req_ready, busy, wd_ready, pad_stb, pad_dir, pad_oen, pad_i,
    //  rd_valid, rd_last, rd_data}
    function automatic logic [18:0] obs_now();
        return {bus.req_ready, bus.busy, bus.wd_ready, bus.pad_stb, bus.pad_dir,
                bus.pad_oen, bus.pad_i, bus.rd_valid, bus.rd_last, bus.rd_data};
    endfunction

    task automatic next_cycle();
        @(posedge CK);
        #1;
    endtask

    // Runs one burst starting in an idle cycle (called #1 after a posedge).
    // Returns #1 into the first idle cycle after the burst.
    task automatic run_burst(input bit wr, input int n, input string name);
        int c[16];
        int acc;
        int lastc;
        int t_end;
        bit e_busy, e_stb, e_dir, e_wdr, e_rv, e_rl;
        logic [3:0] e_oen;
        logic [3:0] padc;
        logic [18:0] exp_v;
        logic [18:0] got_v;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            acc += s_gap[k];
            c[k] = 1 + acc + k;
        end
        lastc = c[n-1];
        t_end = wr ? (lastc + TA + 1) : (n + TA + 1);
        for (int t = 0; t < t_end; t++) begin
            e_busy = (t >= 1);
            e_stb  = 1'b0;
            e_dir  = 1'b0;
            e_wdr  = 1'b0;
            e_rv   = 1'b0;
            e_rl   = 1'b0;
            e_oen  = 4'hF;
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    if (t == c[k] + 1) begin
                        e_stb   = 1'b1;
                        m_pad_i = s_data[k];
                    end
                end
                if (t >= c[0] + 1 && t <= lastc + 1) e_oen = 4'h0;
                e_dir = (t >= 1) && (t <= lastc + 1);
                e_wdr = (t >= 1) && (t <= lastc);
            end else begin
                e_stb = (t >= 1) && (t <= n);
                if (t >= 2 && t <= n + 1) begin
                    e_rv      = 1'b1;
                    m_rd_data = s_pc[t-2];
                end
                e_rl = (t == n + 1);
            end
            exp_v = {!e_busy, e_busy, e_wdr, e_stb, e_dir, e_oen, m_pad_i,
                     e_rv, e_rl, m_rd_data};
            got_v = obs_now();
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b want %b (rdy,busy,wdr,stb,dir,oen,i,rv,rl,rd)",
                         name, t, got_v, exp_v);
            end
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
            n_tests++;
            if (err_contention !== m_err) begin
                n_fail++;
                $display("FAIL %s err_contention cycle %0d: got %b want %b",
                         name, t, err_contention, m_err);
            end
            err_clr = 1'b0;
`endif
            // Drive inputs for cycle t.
            bus.req_valid = (t == 0) ? 1'b1 : (s_noise ? 1'($urandom) : 1'b0);
            bus.req_wr    = (t == 0) ? wr : 1'($urandom);
            bus.req_len   = (t == 0) ? 4'(n - 1) : 4'($urandom);
            bus.wd_valid  = (!wr && s_noise) ? 1'($urandom) : 1'b0;
            bus.wd_data   = 4'($urandom);
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    if (t == c[k]) begin
                        bus.wd_valid = 1'b1;
                        bus.wd_data  = s_data[k];
                    end
                end
                padc = s_force0 ? 4'h0 : m_pad_i;
            end else begin
                padc = (t >= 1 && t <= n) ? s_pc[t-1] : 4'($urandom);
            end
            bus.pad_c = padc;
            if (e_stb && e_dir && e_oen == 4'h0 && padc != m_pad_i) m_err = 1'b1;
            next_cycle();
        end
        bus.req_valid = 1'b0;
        bus.wd_valid  = 1'b0;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 16; k++) begin
            s_data[k] = 4'($urandom);
            s_gap[k]  = 0;
            s_pc[k]   = 4'($urandom);
        end
    endtask

    task automatic test_reset();
        logic [18:0] got_v;
        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.pad_c     = '0;
        repeat (3) @(posedge CK);
        #1;
        got_v = obs_now();
        n_tests++;
        if (got_v !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", got_v,
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0});
        end
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
        n_tests++;
        if (err_contention !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", err_contention);
        end
`endif
        RST = 1'b0;
        next_cycle();
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready %b busy %b want 1 0",
                     bus.req_ready, bus.busy);
        end
        m_pad_i   = '0;
        m_rd_data = '0;
        m_err     = 1'b0;
    endtask

    task automatic test_write_basic();
        clear_stim();
        s_data[0] = 4'hA;
        s_data[1] = 4'h5;
        s_data[2] = 4'hF;
        run_burst(1'b1, 3, "write_basic");
    endtask

    task automatic test_write_stall();
        clear_stim();
        s_data[0] = 4'h9;
        s_data[1] = 4'h2;
        s_gap[1]  = 2;
        run_burst(1'b1, 2, "write_stall");
    endtask

    task automatic test_read();
        clear_stim();
        s_pc[0] = 4'h3;
        s_pc[1] = 4'hC;
        run_burst(1'b0, 2, "read_basic");
    endtask

    task automatic test_reset_mid();
        logic [18:0] got_v;
        logic [3:0]  p0;
        p0            = 4'($urandom);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_len   = 4'd3;
        next_cycle();
        bus.req_valid = 1'b0;
        bus.pad_c     = p0;
        n_tests++;
        if (bus.pad_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid strobe1: got %b want 1", bus.pad_stb);
        end
        next_cycle();
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== p0 || bus.pad_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid beat0: got v%b d%h s%b want v1 d%h s1",
                     bus.rd_valid, bus.rd_data, bus.pad_stb, p0);
        end
        RST       = 1'b1;
        bus.pad_c = 4'($urandom);
        next_cycle();
        got_v = obs_now();
        n_tests++;
        if (got_v !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_mid values: got %b want %b", got_v,
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0});
        end
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            got_v = obs_now();
            n_tests++;
            if (got_v !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_mid idle %0d: got %b want %b", i, got_v,
                         {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0});
            end
        end
        m_pad_i   = '0;
        m_rd_data = '0;
        m_err     = 1'b0;
        clear_stim();
        run_burst(1'b0, 4, "read_after_reset");
    endtask

    task automatic test_full_len();
        clear_stim();
        run_burst(1'b1, 16, "write_full");
        clear_stim();
        run_burst(1'b0, 16, "read_full");
    endtask

    task automatic test_back_to_back();
        clear_stim();
        run_burst(1'b0, 1, "b2b_rd1");
        clear_stim();
        run_burst(1'b0, 1, "b2b_rd1b");
        clear_stim();
        run_burst(1'b1, 1, "b2b_wr1");
        clear_stim();
        run_burst(1'b1, 1, "b2b_wr1b");
        clear_stim();
        run_burst(1'b0, 3, "b2b_rd3");
    endtask

    task automatic test_random();
        bit wr;
        int n;
        s_noise = 1'b1;
        for (int b = 0; b < 24; b++) begin
            wr = 1'($urandom);
            n  = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(1, 5));
            for (int k = 0; k < 16; k++) begin
                s_data[k] = 4'($urandom);
                s_gap[k]  = int'($urandom_range(0, 2));
                s_pc[k]   = 4'($urandom);
            end
            run_burst(wr, n, "random");
        end
        s_noise = 1'b0;
    endtask

`ifdef BIDIR_PAD_BUS_CONTENTION_EN
    task automatic test_contention();
        clear_stim();
        s_force0  = 1'b1;
        s_data[0] = 4'h6;
        run_burst(1'b1, 1, "contention_wr");
        s_force0  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (err_contention !== 1'b1) begin
                n_fail++;
                $display("FAIL contention_sticky %0d: got %b want 1", i, err_contention);
            end
            next_cycle();
        end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        m_err   = 1'b0;
        n_tests++;
        if (err_contention !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_clear: got %b want 0", err_contention);
        end
        clear_stim();
        s_data[0] = 4'h6;
        run_burst(1'b1, 1, "contention_clean");
    endtask
`endif

    initial begin
        s_noise  = 1'b0;
        s_force0 = 1'b0;
        bus.pad_c = '0;
        test_reset();
        test_write_basic();
        test_write_stall();
        test_read();
        test_reset_mid();
        test_full_len();
        test_back_to_back();
        test_random();
`ifdef BIDIR_PAD_BUS_CONTENTION_EN
        test_contention();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
